alu_operand_loader: RTL and testbench

Input stage of the board-level ALU. It takes the 8-bit switch bank and three push buttons, then synchronises, debounces and edge-detects the buttons. It enforces the load order A, then B, then opcode, and presents registered operands `o_a`, `o_b` and opcode `o_op` to the ALU datapath (AND/OR/ADD/… units). A one-cycle `o_valid` strobe marks a complete, fresh operand set.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/btn_conditioner.sv | 77 +++++++
 rtl/alu_operand_loader.sv | 131 +++++++++++++
 tb/tb_alu_operand_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the board-level ALU: loader FSM states, default widths
// and the opcode values the ALU datapath decodes.
package alu_pkg;

    localparam int N_BITS_DEFAULT = 8;
    localparam int N_OP_DEFAULT   = 6;

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        ST_RSVD = 2'd3
    } load_state_e;

    localparam logic [5:0] OP_AND = 6'd0;
    localparam logic [5:0] OP_OR  = 6'd1;
    localparam logic [5:0] OP_ADD = 6'd2;
    localparam logic [5:0] OP_SUB = 6'd3;
    localparam logic [5:0] OP_XOR = 6'd4;
    localparam logic [5:0] OP_NOT = 6'd5;

endpackage

// File: rtl/btn_conditioner.sv
// Raw push button -> 2-flop synchroniser -> optional debounce -> registered
// rising-edge pulse. Debounce is compiled in with ALU_OPLOAD_DEBOUNCE_EN.
module btn_conditioner
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_press;
    logic w_level;

    if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
        $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 1");
    end

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef ALU_OPLOAD_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_level;

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync2 != r_level) begin
            if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_level = r_level;
`else
    assign w_level = r_sync2;
`endif

    // Registered rising-edge detector: one pulse per accepted 0->1 transition
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_prev  <= w_level;
            r_press <= w_level & ~r_prev;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/alu_operand_loader.sv
// ALU input stage: conditions three load buttons, enforces the A -> B -> opcode
// load order and strobes o_valid on a complete set. Debounce: ALU_OPLOAD_DEBOUNCE_EN.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int N_BITS          = N_BITS_DEFAULT,
    parameter int N_OP            = N_OP_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] i_sw,
    input  logic              i_btn_a,
    input  logic              i_btn_b,
    input  logic              i_btn_op,
    output logic [N_BITS-1:0] o_a,
    output logic [N_BITS-1:0] o_b,
    output logic [N_OP-1:0]   o_op,
    output logic              o_valid,
    output logic [1:0]        o_state
);

    logic [N_BITS-1:0] r_sw1;
    logic [N_BITS-1:0] r_sw2;
    logic [N_BITS-1:0] r_a;
    logic [N_BITS-1:0] r_b;
    logic [N_OP-1:0]   r_op;
    logic              r_valid;
    load_state_e       r_state;
    load_state_e       w_state_nxt;
    logic              w_press_a;
    logic              w_press_b;
    logic              w_press_op;
    logic              w_load_a;
    logic              w_load_b;
    logic              w_load_op;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_a (
        .clk(clk), .reset(reset), .i_btn(i_btn_a), .o_press(w_press_a)
    );
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_b (
        .clk(clk), .reset(reset), .i_btn(i_btn_b), .o_press(w_press_b)
    );
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_op (
        .clk(clk), .reset(reset), .i_btn(i_btn_op), .o_press(w_press_op)
    );

    // Switch bank synchroniser; loads always take the second stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw1 <= '0;
            r_sw2 <= '0;
        end else begin
            r_sw1 <= i_sw;
            r_sw2 <= r_sw1;
        end
    end

    // Only the press matching the current state advances; others are dropped
    always_comb begin
        w_state_nxt = r_state;
        w_load_a    = 1'b0;
        w_load_b    = 1'b0;
        w_load_op   = 1'b0;
        case (r_state)
            WAIT_A: begin
                if (w_press_a) begin
                    w_load_a    = 1'b1;
                    w_state_nxt = WAIT_B;
                end else begin
                    w_state_nxt = WAIT_A;
                end
            end
            WAIT_B: begin
                if (w_press_b) begin
                    w_load_b    = 1'b1;
                    w_state_nxt = WAIT_OP;
                end else begin
                    w_state_nxt = WAIT_B;
                end
            end
            WAIT_OP: begin
                if (w_press_op) begin
                    w_load_op   = 1'b1;
                    w_state_nxt = WAIT_A;
                end else begin
                    w_state_nxt = WAIT_OP;
                end
            end
            ST_RSVD: w_state_nxt = WAIT_A;
            default: w_state_nxt = WAIT_A;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WAIT_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand/opcode registers hold until reloaded; valid is a single-cycle strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_load_a) begin
                r_a <= r_sw2;
            end
            if (w_load_b) begin
                r_b <= r_sw2;
            end
            if (w_load_op) begin
                r_op <= r_sw2[N_OP-1:0];
            end
            r_valid <= w_load_op;
        end
    end

    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_op    = r_op;
    assign o_valid = r_valid;
    assign o_state = r_state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: table-driven load sequences,
// hand-written timing/reset/debounce sequences, and a randomized history-based model.
module tb_alu_operand_loader;

    localparam int D = 16;
`ifdef ALU_OPLOAD_DEBOUNCE_EN
    localparam int LAT  = 3 + D;
    localparam int PH   = D + 4;
    localparam int IDLE = LAT + D + 6;
`else
    localparam int LAT  = 3;
    localparam int PH   = 2;
    localparam int IDLE = LAT + 4;
`endif
    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] i_sw;
    logic       i_btn_a, i_btn_b, i_btn_op;
    logic [7:0] o_a, o_b;
    logic [5:0] o_op;
    logic       o_valid;
    logic [1:0] o_state;

    alu_operand_loader #(.N_BITS(8), .N_OP(6), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .i_sw(i_sw),
        .i_btn_a(i_btn_a), .i_btn_b(i_btn_b), .i_btn_op(i_btn_op),
        .o_a(o_a), .o_b(o_b), .o_op(o_op), .o_valid(o_valid), .o_state(o_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int vcnt   = 0;

    // Reference model: raw input history per edge, effects derived from spec rules
    logic [2:0] h_btn [MAXC];
    logic [7:0] h_sw  [MAXC];
    int         last_rst = -1;
    logic [7:0] m_a = 8'd0, m_b = 8'd0;
    logic [5:0] m_op = 6'd0;
    logic       m_valid = 1'b0;
    int         m_state = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic raw(input int b, input int idx);
        if (idx < 0 || idx <= last_rst) return 1'b0;
        return h_btn[idx][b];
    endfunction

    function automatic logic [7:0] sw_at(input int idx);
        if (idx < 0 || idx <= last_rst) return 8'd0;
        return h_sw[idx];
    endfunction

    task automatic model_step(input int k, input logic rst);
        logic pa, pb, po;
        if (rst) begin
            last_rst = k;
            m_a = 8'd0; m_b = 8'd0; m_op = 6'd0; m_valid = 1'b0; m_state = 0;
        end else begin
            pa = raw(0, k - LAT) & ~raw(0, k - LAT - 1);
            pb = raw(1, k - LAT) & ~raw(1, k - LAT - 1);
            po = raw(2, k - LAT) & ~raw(2, k - LAT - 1);
            m_valid = 1'b0;
            if (m_state == 0 && pa) begin
                m_a = sw_at(k - 2); m_state = 1;
            end else if (m_state == 1 && pb) begin
                m_b = sw_at(k - 2); m_state = 2;
            end else if (m_state == 2 && po) begin
                m_op = sw_at(k - 2) & 8'h3F; m_valid = 1'b1; m_state = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        h_btn[cyc] = {i_btn_op, i_btn_b, i_btn_a};
        h_sw[cyc]  = i_sw;
        model_step(cyc, reset);
        #1;
`ifndef ALU_OPLOAD_DEBOUNCE_EN
        chk("model_a", {24'd0, o_a}, {24'd0, m_a});
        chk("model_b", {24'd0, o_b}, {24'd0, m_b});
        chk("model_op", {26'd0, o_op}, {26'd0, m_op});
        chk("model_valid", {31'd0, o_valid}, {31'd0, m_valid});
        chk("model_state", {30'd0, o_state}, 32'(m_state));
`endif
        if (o_valid) vcnt++;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic [2:0] btns, input logic [7:0] sw, input int hold);
        i_sw = sw;
        idle(3);
        {i_btn_op, i_btn_b, i_btn_a} = btns;
        idle(hold);
        {i_btn_op, i_btn_b, i_btn_a} = 3'b000;
        idle(IDLE);
    endtask

    typedef struct {
        logic [7:0] sw;
        logic [2:0] btns;   // {op, b, a}
        int         hold;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic [5:0] exp_op;
        logic [1:0] exp_state;
        int         exp_vcnt;
    } vec_t;

    vec_t vecs [9];

    initial begin
        reset = 1'b1; i_sw = 8'h00; i_btn_a = 1'b0; i_btn_b = 1'b0; i_btn_op = 1'b0;

        vecs[0] = '{8'h3C, 3'b001, PH, 8'h3C, 8'h00, 6'h00, 2'd1, 0};
        vecs[1] = '{8'h0F, 3'b010, PH, 8'h3C, 8'h0F, 6'h00, 2'd2, 0};
        vecs[2] = '{8'h20, 3'b100, PH, 8'h3C, 8'h0F, 6'h20, 2'd0, 1};
        vecs[3] = '{8'hAA, 3'b010, PH, 8'h3C, 8'h0F, 6'h20, 2'd0, 0};
        vecs[4] = '{8'hAA, 3'b100, PH, 8'h3C, 8'h0F, 6'h20, 2'd0, 0};
        vecs[5] = '{8'h11, 3'b001, PH, 8'h11, 8'h0F, 6'h20, 2'd1, 0};
        vecs[6] = '{8'h55, 3'b011, PH, 8'h11, 8'h55, 6'h20, 2'd2, 0};
        vecs[7] = '{8'h07, 3'b100, PH, 8'h11, 8'h55, 6'h07, 2'd0, 1};
        vecs[8] = '{8'h99, 3'b001, 50, 8'h99, 8'h55, 6'h07, 2'd1, 0};

        idle(3);
        chk("reset_a", {24'd0, o_a}, 32'd0);
        chk("reset_b", {24'd0, o_b}, 32'd0);
        chk("reset_op", {26'd0, o_op}, 32'd0);
        chk("reset_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_state", {30'd0, o_state}, 32'd0);
        reset = 1'b0;
        idle(2);

        for (int v = 0; v < 9; v++) begin
            vcnt = 0;
            press(vecs[v].btns, vecs[v].sw, vecs[v].hold);
            chk($sformatf("vec%0d_a", v), {24'd0, o_a}, {24'd0, vecs[v].exp_a});
            chk($sformatf("vec%0d_b", v), {24'd0, o_b}, {24'd0, vecs[v].exp_b});
            chk($sformatf("vec%0d_op", v), {26'd0, o_op}, {26'd0, vecs[v].exp_op});
            chk($sformatf("vec%0d_state", v), {30'd0, o_state}, {30'd0, vecs[v].exp_state});
            chk($sformatf("vec%0d_vcnt", v), 32'(vcnt), 32'(vecs[v].exp_vcnt));
        end

        // Exact o_valid timing relative to the first edge seeing the raw op button
        press(3'b010, 8'h01, PH);
        i_sw = 8'h2A;
        idle(3);
        i_btn_op = 1'b1;
        for (int i = 0; i <= LAT + 3; i++) begin
            tick();
            chk($sformatf("vtime%0d_valid", i), {31'd0, o_valid}, {31'd0, (i == LAT)});
            chk($sformatf("vtime%0d_state", i), {30'd0, o_state}, (i >= LAT) ? 32'd0 : 32'd2);
        end
        chk("vtime_op", {26'd0, o_op}, 32'h2A);
        i_btn_op = 1'b0;
        idle(IDLE);

        // Reset in WAIT_OP discards everything; a later op press gives no valid
        press(3'b001, 8'hFF, PH);
        press(3'b010, 8'h01, PH);
        chk("prerst_state", {30'd0, o_state}, 32'd2);
        chk("prerst_a", {24'd0, o_a}, 32'hFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_a", {24'd0, o_a}, 32'd0);
        chk("rst_b", {24'd0, o_b}, 32'd0);
        chk("rst_op", {26'd0, o_op}, 32'd0);
        chk("rst_state", {30'd0, o_state}, 32'd0);
        vcnt = 0;
        press(3'b100, 8'h13, PH);
        chk("rst_no_valid", 32'(vcnt), 32'd0);
        chk("rst_op_after", {26'd0, o_op}, 32'd0);
        chk("rst_state_after", {30'd0, o_state}, 32'd0);

`ifdef ALU_OPLOAD_DEBOUNCE_EN
        // Short glitch is rejected; a 20-cycle press loads A at t0+19
        press(3'b001, 8'h77, 10);
        chk("glitch_state", {30'd0, o_state}, 32'd0);
        chk("glitch_a", {24'd0, o_a}, 32'd0);
        i_sw = 8'h5A;
        idle(3);
        i_btn_a = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i == 20) i_btn_a = 1'b0;
            tick();
            chk($sformatf("deb%0d_a", i), {24'd0, o_a}, (i >= 19) ? 32'h5A : 32'd0);
        end
        idle(IDLE);
        chk("deb_state", {30'd0, o_state}, 32'd1);
`else
        // Randomized traffic against the history model, with occasional resets
        for (int i = 0; i < 1500; i++) begin
            i_sw = 8'($urandom);
            if ($urandom_range(0, 5) == 0) i_btn_a  = ~i_btn_a;
            if ($urandom_range(0, 5) == 0) i_btn_b  = ~i_btn_b;
            if ($urandom_range(0, 5) == 0) i_btn_op = ~i_btn_op;
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        {i_btn_op, i_btn_b, i_btn_a} = 3'b000;
        idle(IDLE);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
